price_frame_sequencer: RTL and testbench

- Sequences the trading datapath between the UART byte interface and the RSI/signal engine inside hft_accelerator.
- Assembles four received bytes, big-endian, into one Q16.16 price and issues it to the engine with a valid/ready handshake.
- Waits for the engine's trade decision, then hands one ASCII response byte to the UART transmitter.
- Enforces inter-byte frame timeout, response timeout, and overrun accounting.

---
 rtl/price_frame_sequencer.sv | 167 ++++++++++++++++
 tb/tb_price_frame_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/price_frame_sequencer.sv
// rtl/price_frame_sequencer.sv - UART-to-signal-engine price frame sequencer (optional ECHO_PRICE_EN price echo)
module price_frame_sequencer #(
   parameter int TIMEOUT_CYCLES      = 100_000,
   parameter int RESP_TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [31:0] price_data,
   output logic        price_valid,
   input  logic        price_ready,
   input  logic        sig_valid,
   input  logic [1:0]  sig_code,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic [7:0]  err_cnt
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      COLLECT  = 3'd1,
      ISSUE    = 3'd2,
      WAIT_SIG = 3'd3,
      SEND     = 3'd4
   } state_t;

   localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int RTW = (RESP_TIMEOUT_CYCLES > 1) ? $clog2(RESP_TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [RTW-1:0] RTO_LAST = RTW'(RESP_TIMEOUT_CYCLES - 1);

   state_t         state;
   state_t         state_next;
   logic [31:0]    shift;
   logic [2:0]     byte_cnt;
   logic [TW-1:0]  timer;
   logic [RTW-1:0] resp_timer;
   logic [7:0]     resp_byte;
   logic           coll_to;
   logic           resp_to;
   logic           overrun;
   logic           err_inc;
   logic [7:0]     sig_byte;
`ifdef ECHO_PRICE_EN
   logic [2:0]     send_idx;
`endif

   // Event decode: timeouts only fire when no competing strobe arrives that cycle
   always_comb begin
      coll_to  = (state == COLLECT) && !rx_valid && (timer == TO_LAST);
      resp_to  = (state == WAIT_SIG) && !sig_valid && (resp_timer == RTO_LAST);
      overrun  = rx_valid && ((state == ISSUE) || (state == WAIT_SIG) || (state == SEND));
      err_inc  = coll_to || resp_to || overrun;
      case (sig_code)
         2'b00:   sig_byte = 8'h48;
         2'b01:   sig_byte = 8'h42;
         2'b10:   sig_byte = 8'h53;
         default: sig_byte = 8'h45;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (rx_valid) state_next = COLLECT;
         COLLECT: begin
            if (rx_valid && (byte_cnt == 3'd3)) state_next = ISSUE;
            else if (coll_to)                   state_next = IDLE;
         end
         ISSUE:    if (price_ready) state_next = WAIT_SIG;
         WAIT_SIG: if (sig_valid || resp_to) state_next = SEND;
         SEND: begin
`ifdef ECHO_PRICE_EN
            if (tx_ready && (send_idx == 3'd4)) state_next = IDLE;
`else
            if (tx_ready) state_next = IDLE;
`endif
         end
         default:  state_next = IDLE;
      endcase
   end

   // Datapath: frame assembly, timers, response latch and error counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift      <= '0;
         byte_cnt   <= '0;
         timer      <= '0;
         resp_timer <= '0;
         resp_byte  <= '0;
         err_cnt    <= '0;
`ifdef ECHO_PRICE_EN
         send_idx   <= '0;
`endif
      end else begin
         if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
         case (state)
            IDLE: begin
               if (rx_valid) begin
                  shift    <= {24'h0, rx_data};
                  byte_cnt <= 3'd1;
                  timer    <= '0;
               end
`ifdef ECHO_PRICE_EN
               send_idx <= '0;
`endif
            end
            COLLECT: begin
               if (rx_valid) begin
                  shift    <= {shift[23:0], rx_data};
                  byte_cnt <= byte_cnt + 3'd1;
                  timer    <= '0;
               end else if (coll_to) begin
                  timer    <= '0;
                  byte_cnt <= '0;
               end else begin
                  timer    <= timer + TW'(1);
               end
            end
            ISSUE: begin
               if (price_ready) resp_timer <= '0;
            end
            WAIT_SIG: begin
               if (sig_valid)    resp_byte  <= sig_byte;
               else if (resp_to) resp_byte  <= 8'h45;
               else              resp_timer <= resp_timer + RTW'(1);
            end
            SEND: begin
`ifdef ECHO_PRICE_EN
               if (tx_ready) send_idx <= (send_idx == 3'd4) ? 3'd0 : send_idx + 3'd1;
`endif
            end
            default: ;
         endcase
      end
   end

   // Output decode from state and held registers
   always_comb begin
      price_data  = shift;
      price_valid = (state == ISSUE);
      tx_valid    = (state == SEND);
      busy        = (state != IDLE);
`ifdef ECHO_PRICE_EN
      case (send_idx)
         3'd0:    tx_data = resp_byte;
         3'd1:    tx_data = shift[31:24];
         3'd2:    tx_data = shift[23:16];
         3'd3:    tx_data = shift[15:8];
         default: tx_data = shift[7:0];
      endcase
`else
      tx_data = resp_byte;
`endif
   end

endmodule

// File: tb/tb_price_frame_sequencer.sv
// tb/tb_price_frame_sequencer.sv - scoreboard bench for price_frame_sequencer
module tb_price_frame_sequencer;

   localparam int TO  = 16;
   localparam int RTO = 40;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [31:0] price_data;
   logic        price_valid;
   logic        price_ready = 1'b0;
   logic        sig_valid = 1'b0;
   logic [1:0]  sig_code = '0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        busy;
   logic [7:0]  err_cnt;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_price[$];
   logic [7:0]  exp_tx[$];
   logic [31:0] cur_price = '0;
   logic [7:0]  exp_err = '0;

   price_frame_sequencer #(.TIMEOUT_CYCLES(TO), .RESP_TIMEOUT_CYCLES(RTO)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .price_data(price_data), .price_valid(price_valid), .price_ready(price_ready),
      .sig_valid(sig_valid), .sig_code(sig_code), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pop and compare on every completed handshake
   always @(negedge clk) begin
      if (rst_n) begin
         if (price_valid && price_ready) begin
            if (exp_price.size() == 0) check("price_unexpected", price_data, 32'hxxxx_xxxx);
            else check("price_data", price_data, exp_price.pop_front());
         end
         if (tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) check("tx_unexpected", {24'h0, tx_data}, 32'hxxxx_xxxx);
            else check("tx_data", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b; rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
   endtask

   task automatic frame(input logic [7:0] b0, b1, b2, b3, input logic [31:0] exp);
      exp_price.push_back(exp);
      cur_price = exp;
      send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
   endtask

   task automatic push_resp(input logic [7:0] code);
      exp_tx.push_back(code);
`ifdef ECHO_PRICE_EN
      exp_tx.push_back(cur_price[31:24]);
      exp_tx.push_back(cur_price[23:16]);
      exp_tx.push_back(cur_price[15:8]);
      exp_tx.push_back(cur_price[7:0]);
`endif
   endtask

   task automatic drive_sig(input logic [1:0] code);
      sig_valid = 1'b1; sig_code = code;
      tick(1);
      sig_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (busy && n < budget) begin tick(1); n++; end
      check(name, {31'h0, busy}, 32'h0);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_pvalid", {31'h0, price_valid}, 32'h0);
      check("rst_pdata", price_data, 32'h0);
      check("rst_txvalid", {31'h0, tx_valid}, 32'h0);
      check("rst_txdata", {24'h0, tx_data}, 32'h0);
      check("rst_errcnt", {24'h0, err_cnt}, 32'h0);
      exp_tx.delete();
      exp_price.delete();
      exp_err = '0;
      #2 rst_n = 1'b1;
      tick(1);
   endtask

   initial begin
      tick(2);
      check("reset_busy", {31'h0, busy}, 32'h0);
      check("reset_err", {24'h0, err_cnt}, 32'h0);
      check("reset_tx", {31'h0, tx_valid}, 32'h0);
      rst_n = 1'b1;
      tick(1);

      // Back-to-back frame, buy decision, transmitter stalled then released
      price_ready = 1'b1;
      exp_price.push_back(32'h0096_0000);
      cur_price = 32'h0096_0000;
      send_byte(8'h00); send_byte(8'h96); send_byte(8'h00);
      check("pv_before_4th", {31'h0, price_valid}, 32'h0);
      send_byte(8'h00);
      check("pv_latency", {31'h0, price_valid}, 32'h1);
      tick(1);
      push_resp(8'h42);
      drive_sig(2'b01);
      for (int i = 0; i < 3; i++) begin
         check("tx_hold_valid", {31'h0, tx_valid}, 32'h1);
         check("tx_hold_data", {24'h0, tx_data}, 32'h42);
         tick(1);
      end
      tx_ready = 1'b1;
      wait_idle("idle_after_buy", 20);

      // Inter-byte timeout, then a clean frame with hold decision
      send_byte(8'h00); send_byte(8'h94);
      tick(TO + 2);
      exp_err = exp_err + 8'd1;
      check("timeout_busy", {31'h0, busy}, 32'h0);
      check("timeout_err", {24'h0, err_cnt}, {24'h0, exp_err});
      frame(8'h00, 8'h94, 8'h80, 8'h00, 32'h0094_8000);
      tick(1);
      push_resp(8'h48);
      drive_sig(2'b00);
      wait_idle("idle_after_hold", 20);

      // Engine stall for 50 cycles with three overrun strobes, then sell
      price_ready = 1'b0;
      frame(8'h12, 8'h34, 8'h56, 8'h78, 32'h1234_5678);
      for (int i = 0; i < 50; i++) begin
         rx_data = 8'hEE;
         rx_valid = (i == 10 || i == 20 || i == 30);
         tick(1);
         rx_valid = 1'b0;
         check("stall_pvalid", {31'h0, price_valid}, 32'h1);
         check("stall_pdata", price_data, 32'h1234_5678);
      end
      exp_err = exp_err + 8'd3;
      check("overrun_err", {24'h0, err_cnt}, {24'h0, exp_err});
      price_ready = 1'b1;
      tick(1);
      push_resp(8'h53);
      drive_sig(2'b10);
      wait_idle("idle_after_sell", 20);

      // Response timeout produces 'E'
      frame(8'h01, 8'h02, 8'h03, 8'h04, 32'h0102_0304);
      push_resp(8'h45);
      tick(RTO + 4);
      wait_idle("idle_after_resp_to", 20);
      exp_err = exp_err + 8'd1;
      check("resp_to_err", {24'h0, err_cnt}, {24'h0, exp_err});

      // Engine error code
      frame(8'h7F, 8'hFF, 8'h00, 8'h01, 32'h7FFF_0001);
      tick(1);
      push_resp(8'h45);
      drive_sig(2'b11);
      wait_idle("idle_after_err", 20);
      check("err_code_errcnt", {24'h0, err_cnt}, {24'h0, exp_err});

      // Reset in the middle of COLLECT, then a full frame from byte one
      send_byte(8'hAA); send_byte(8'hBB);
      pulse_reset();
      frame(8'hAA, 8'hBB, 8'hCC, 8'hDD, 32'hAABB_CCDD);
      check("post_rst_pdata", price_data, 32'hAABB_CCDD);
      tick(1);
      push_resp(8'h42);
      drive_sig(2'b01);
      wait_idle("idle_after_rst_frame", 20);

      // Reset in the middle of SEND
      tx_ready = 1'b0;
      frame(8'h11, 8'h22, 8'h33, 8'h44, 32'h1122_3344);
      tick(1);
      push_resp(8'h48);
      drive_sig(2'b00);
      check("send_txvalid", {31'h0, tx_valid}, 32'h1);
      check("send_pdata", price_data, cur_price);
      pulse_reset();

      // Sell with a randomly toggling transmitter
      frame(8'h00, 8'h82, 8'h00, 8'h00, 32'h0082_0000);
      tick(1);
      push_resp(8'h53);
      drive_sig(2'b10);
      begin
         int n = 0;
         while (busy && n < 200) begin
            tx_ready = 1'($urandom_range(0, 1));
            tick(1);
            n++;
         end
      end
      check("echo_idle", {31'h0, busy}, 32'h0);
      tx_ready = 1'b0;
      tick(3);
      check("tx_queue_empty", exp_tx.size(), 32'h0);
      check("price_queue_empty", exp_price.size(), 32'h0);
      check("final_err", {24'h0, err_cnt}, {24'h0, exp_err});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
